// File: rtl/ann_weight_pkg.sv
// ann_weight_pkg
// Shared constants and types for the neuron weight path.
//   WEIGHT_W            : weight word width (BRAM DO width)
//   WEIGHT_ADDR_W       : weight BRAM address width
//   WEIGHTS_PER_NEURON  : words stored per neuron
//   weight_rd_state_t   : weight reader FSM states
package ann_weight_pkg;

    localparam int WEIGHT_W           = 16;
    localparam int WEIGHT_ADDR_W      = 5;
    localparam int WEIGHTS_PER_NEURON = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } weight_rd_state_t;

endpackage

// File: rtl/weight_rd_fifo2.sv
// weight_rd_fifo2
// Two-entry synchronous FIFO used as the reader's output skid buffer.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write side (ignored when full and not popping)
//   i_pop          : read side (ignored when empty)
//   o_data         : head entry (valid when o_count != 0)
//   o_count        : occupancy 0..2
module weight_rd_fifo2 #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is allowed only when the head leaves the same cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/weight_bram_reader.sv
// weight_bram_reader
// Read-side initiator for a negedge-clocked weight BRAM. On START it reads
// DEPTH consecutive words from BASE_ADDR and streams them in address order on
// a valid/ready interface. Never writes the BRAM.
// Optional: define WEIGHT_READER_CHECKSUM_EN to add o_checksum, the modulo
// 2**DATA_W sum of all words handshaked in the current pass.
// Ports:
//   i_clk, i_rst_n      : clock (posedge), async active-low reset
//   i_start             : pass request, honoured when not busy (or on the DONE edge)
//   o_busy, o_done      : pass in progress / one-cycle completion pulse
//   o_bram_addr/en/we   : registered BRAM controls (we tied 0)
//   i_bram_do           : BRAM read data, valid one cycle after issue
//   o_w_data/index/last : stream payload, o_w_valid / i_w_ready handshake
//   o_checksum          : (optional) running sum of handshaked words
module weight_bram_reader
    import ann_weight_pkg::*;
#(
    parameter int DATA_W    = WEIGHT_W,
    parameter int ADDR_W    = WEIGHT_ADDR_W,
    parameter int DEPTH     = WEIGHTS_PER_NEURON,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_en,
    output logic              o_bram_we,
    input  logic [DATA_W-1:0] i_bram_do,
`ifdef WEIGHT_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] o_checksum,
`endif
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic              o_w_last,
    output logic [ADDR_W-1:0] o_w_index
);

    localparam int CNT_W = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);
    localparam int EW    = DATA_W + ADDR_W + 1;

    if ((BASE_ADDR + DEPTH - 1) > ((1 << ADDR_W) - 1) || DEPTH < 1) begin : g_range_err
        $error("weight_bram_reader: BASE_ADDR+DEPTH-1 exceeds BRAM address range");
    end

    weight_rd_state_t  r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_issue_cnt, w_issue_cnt_nxt;
    logic [CNT_W-1:0]  w_idx;
    logic              w_accept, w_issue;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_if_idx;
    logic              r_if_last;
    logic [1:0]        w_fifo_cnt;
    logic [EW-1:0]     w_head;
    logic              w_pop, w_last_pop;
    logic [2:0]        w_occ;

    assign o_w_valid  = (w_fifo_cnt != 2'd0);
    assign w_pop      = o_w_valid && i_w_ready;
    assign w_last_pop = w_pop && o_w_last;
    // Words already owed to the buffer after this edge; issue only if room for one more.
    assign w_occ      = {1'b0, w_fifo_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_issue         = 1'b0;
        w_idx           = r_issue_cnt;
        w_issue_cnt_nxt = r_issue_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_accept = 1'b1;
            end
            RUN: begin
                if (w_occ < 3'd2) w_issue = 1'b1;
            end
            DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // A START on the completing edge chains straight into a new pass.
                    if (i_start) w_accept = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            w_issue     = 1'b1;
            w_idx       = '0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = RUN;
        end
        if (w_issue) begin
            w_issue_cnt_nxt = w_idx + 1'b1;
            if (w_idx == CNT_W'(DEPTH - 1)) w_state_nxt = DRAIN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issue_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_inflight  <= 1'b0;
            r_if_idx    <= '0;
            r_if_last   <= 1'b0;
        end else begin
            r_issue_cnt <= w_issue_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_bram_en   <= w_issue;
            r_inflight  <= w_issue;
            if (w_issue) begin
                r_bram_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(w_idx);
                r_if_idx    <= ADDR_W'(w_idx);
                r_if_last   <= (w_idx == CNT_W'(DEPTH - 1));
            end
        end
    end

    // Read data from the previous issue is captured into the buffer with its tag.
    weight_rd_fifo2 #(.W(EW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  ({i_bram_do, r_if_idx, r_if_last}),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign {o_w_data, o_w_index, o_w_last} = w_head;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_bram_en   = r_bram_en;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_we   = 1'b0;

`ifdef WEIGHT_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_checksum <= '0;
        else if (w_accept) r_checksum <= '0;
        else if (w_pop)  r_checksum <= r_checksum + o_w_data;
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// tb_weight_bram_reader
// Randomized bench for weight_bram_reader against a word-sequence reference:
// the k-th handshake of a pass must carry mem[BASE+k], index k, last at DEPTH-1.
// A second instance covers BASE_ADDR=4, DEPTH=1.
module tb_weight_bram_reader;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 28;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0 (defaults)
    logic          start, busy, done, bram_en, bram_we, w_valid, w_ready, w_last;
    logic [AW-1:0] bram_addr, w_index;
    logic [DW-1:0] bram_do, w_data;
    // DUT1 (BASE_ADDR=4, DEPTH=1)
    logic          start1, busy1, done1, bram_en1, bram_we1, w_valid1, w_ready1, w_last1;
    logic [AW-1:0] bram_addr1, w_index1;
    logic [DW-1:0] bram_do1, w_data1;
`ifdef WEIGHT_READER_CHECKSUM_EN
    logic [DW-1:0] checksum, checksum1;
`endif

    logic [DW-1:0] mem [32];

    weight_bram_reader u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_bram_addr(bram_addr), .o_bram_en(bram_en), .o_bram_we(bram_we), .i_bram_do(bram_do),
`ifdef WEIGHT_READER_CHECKSUM_EN
        .o_checksum(checksum),
`endif
        .o_w_data(w_data), .o_w_valid(w_valid), .i_w_ready(w_ready),
        .o_w_last(w_last), .o_w_index(w_index)
    );

    weight_bram_reader #(.BASE_ADDR(4), .DEPTH(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_bram_addr(bram_addr1), .o_bram_en(bram_en1), .o_bram_we(bram_we1), .i_bram_do(bram_do1),
`ifdef WEIGHT_READER_CHECKSUM_EN
        .o_checksum(checksum1),
`endif
        .o_w_data(w_data1), .o_w_valid(w_valid1), .i_w_ready(w_ready1),
        .o_w_last(w_last1), .o_w_index(w_index1)
    );

    // Negedge-clocked BRAM read ports.
    always @(negedge clk) begin
        if (bram_en)  bram_do  <= mem[bram_addr];
        if (bram_en1) bram_do1 <= mem[bram_addr1];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream monitor / scoreboard for DUT0.
    int   e_idx = 0, hs = 0, iss = 0, max_out = 0, done_cnt = 0, done_cyc = 0;
    int   first_v = -1, hs_first = 0, hs_last = 0;
    bit   we_bad = 0;
    logic stall_prev = 1'b0;
    logic [DW+AW:0] stall_v;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            e_idx      = 0;
            stall_prev = 1'b0;
        end else begin
            if (bram_we) we_bad = 1;
            if (stall_prev) begin
                chk("stall_valid", w_valid, 1);
                chk("stall_payload", {w_last, w_index, w_data}, stall_v);
            end
            if (bram_en) iss++;
            if (iss - hs > max_out) max_out = iss - hs;
            if (w_valid && first_v < 0) first_v = cyc;
            if (w_valid && w_ready) begin
                chk("hs_index", w_index, e_idx);
                chk("hs_data", w_data, mem[e_idx]);
                chk("hs_last", w_last, (e_idx == DEPTH - 1));
                if (hs == 0) hs_first = cyc;
                hs_last = cyc;
                hs++;
                e_idx = (e_idx + 1) % DEPTH;
            end
            stall_prev = w_valid && !w_ready;
            stall_v    = {w_last, w_index, w_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clr();
        hs = 0; iss = 0; max_out = 0; done_cnt = 0; first_v = -1; we_bad = 0;
    endtask

    task automatic pulse(output int acc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done_cnt == 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", done_cnt != 0, 1);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, busy_low;
        rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start1 = 1'b0; w_ready1 = 1'b1;
        fill_ramp();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, done, bram_en, bram_we, w_valid, w_last}, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_data", w_data, 0);
        chk("rst_index", w_index, 0);
        rst_n = 1'b1;

        // Basic pass, ready held high.
        w_ready = 1'b1;
        clr();
        pulse(acc);
        chk("busy_on_accept", busy, 1);
        wait_done(100);
        chk("first_valid_lat", first_v - acc, 1);
        chk("burst_span", hs_last - hs_first, DEPTH - 1);
        chk("done_lat", done_cyc - acc, DEPTH + 1);
        chk("basic_words", hs, DEPTH);
        chk("we_zero", we_bad, 0);
`ifdef WEIGHT_READER_CHECKSUM_EN
        chk("checksum", checksum, 16'h1D7A);
`endif
        repeat (3) @(posedge clk);
        #1 chk("basic_done_once", done_cnt, 1);
        chk("idle_busy", busy, 0);

        // Backpressure: stall cycles 5..9, random ready afterwards.
        clr();
        pulse(acc);
`ifdef WEIGHT_READER_CHECKSUM_EN
        chk("checksum_clear", checksum, 0);
`endif
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            if (cyc - acc >= 5 && cyc - acc <= 9) w_ready = 1'b0;
            else if (cyc - acc < 5)               w_ready = 1'b1;
            else                                  w_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("bp_done_seen", done_cnt != 0, 1);
        w_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_words", hs, DEPTH);
        chk("bp_outstanding_le2", max_out <= 2, 1);
        chk("bp_done_once", done_cnt, 1);

        // START while busy is ignored; START on the completing edge chains a pass.
        clr();
        pulse(acc);
        repeat (9) @(posedge clk);
        #1;
        pulse(acc2);
        for (int n = 0; n < 100 && !(w_valid && w_last); n++) begin
            @(posedge clk); #1;
        end
        chk("p1_last_seen", w_valid && w_last, 1);
        chk("p1_busy_start_ignored", done_cnt, 0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        acc = cyc;
        chk("chain_done", done, 1);
        chk("chain_busy", busy, 1);
        busy_low = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            if (!busy) busy_low++;
        end
        @(posedge clk); #1;
        chk("p2_done_lat", done, 1);
        chk("p2_busy_continuous", busy_low, 0);
        chk("p2_words", hs, 2 * DEPTH);
        @(posedge clk); #1;
        chk("p12_done_count", done_cnt, 2);

        // Reset mid-pass.
        clr();
        pulse(acc);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ctrl", {busy, done, bram_en, w_valid, w_last}, 0);
        chk("mrst_addr", bram_addr, 0);
        chk("mrst_data", w_data, 0);
        chk("mrst_index", w_index, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        pulse(acc);
        wait_done(100);
        chk("post_rst_words", hs, DEPTH);
        chk("post_rst_done_lat", done_cyc - acc, DEPTH + 1);

        // Random memory contents with random ready.
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        clr();
        pulse(acc);
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            w_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("rnd_done_seen", done_cnt != 0, 1);
        w_ready = 1'b1;
        chk("rnd_words", hs, DEPTH);
        chk("rnd_outstanding_le2", max_out <= 2, 1);

        // BASE_ADDR=4, DEPTH=1 instance.
        fill_ramp();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("d1_busy", busy1, 1);
        chk("d1_valid_early", w_valid1, 0);
        @(posedge clk); #1;
        chk("d1_valid", w_valid1, 1);
        chk("d1_data", w_data1, mem[4]);
        chk("d1_index", w_index1, 0);
        chk("d1_last", w_last1, 1);
        chk("d1_done_early", done1, 0);
        @(posedge clk); #1;
        chk("d1_done", done1, 1);
        chk("d1_busy_end", busy1, 0);
        chk("d1_valid_end", w_valid1, 0);
        chk("d1_we", bram_we1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_bram_reader.md
Name: weight_bram_reader

Overview:
- Read-side initiator for one negedge-clocked weight BRAM: one 16-bit word per address, 28 words per neuron, EN/WE/ADDR/DI/DO interface.
- On START, reads DEPTH consecutive words from BASE_ADDR upward.
- Presents the words in address order on a valid/ready stream to the neuron MAC datapath.
- Never writes: the BRAM write side stays with the weight loader.

Parameters:
- DATA_W, 16, weight word width; equals BRAM DO width.
- ADDR_W, 5, BRAM address width.
- DEPTH, 28, words read per START.
- BASE_ADDR, 0, first address read.
- Elaboration check: BASE_ADDR+DEPTH-1 <= 2**ADDR_W-1, else $error.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin a pass; honoured only when not BUSY.
- BUSY  out  1  high from START acceptance until the DONE cycle (exclusive).
- DONE  out  1  one-cycle pulse after the W_LAST word handshakes.
- BRAM_ADDR  out  ADDR_W  registered address to BRAM ADDR.
- BRAM_EN  out  1  registered enable to BRAM EN.
- BRAM_WE  out  1  constant 0.
- BRAM_DO  in  DATA_W  BRAM read data.
- W_DATA  out  DATA_W  stream data.
- W_VALID  out  1  stream valid.
- W_READY  in  1  stream ready from the consumer.
- W_LAST  out  1  high with the final (DEPTH-1) word.
- W_INDEX  out  ADDR_W  word index 0..DEPTH-1 of W_DATA.

Behaviour:
- Reset (async, RST_N low) clears all outputs to 0, FSM to IDLE, counters to 0, buffer empty, inflight flag 0; takes effect immediately mid-pass, and BRAM_EN drops with reset.
- BRAM timing:
  - Read issued at posedge k (BRAM_EN=1, BRAM_ADDR=a registered).
  - BRAM samples at the negedge inside cycle k; DO is valid before posedge k+1.
  - Reader captures BRAM_DO at posedge k+1 when inflight=1.
  - Read latency is 1 cycle.
- Output buffer: 2-entry FIFO holding {data, index, last}.
  - W_VALID = buffer not empty; W_DATA/W_INDEX/W_LAST come from the head entry.
  - Pop when W_VALID & W_READY.
- Credit rule: issue a read at a posedge iff state==RUN and (count + inflight - pop) < 2. This gives 1 word/cycle with W_READY held high, and no overflow under backpressure.
- When not issuing, BRAM_EN=0; BRAM_ADDR holds its last value.
- FSM:
  - IDLE: on START, go to RUN, issue addr BASE_ADDR the same posedge, issue counter=1, BUSY=1.
  - RUN: issue per the credit rule, address increments by 1 per issue. After issue DEPTH, go to DRAIN.
  - DRAIN: no issues; wait until the W_LAST entry pops. On that pop, go to IDLE, BUSY=0, DONE=1 for one cycle.
- START while BUSY is ignored, with no queuing.
- START in the DONE cycle is accepted: a new pass begins, and DONE and BUSY are both high that cycle.
- W_READY may be high with W_VALID low; nothing happens.
- W_VALID, once high, stays high with stable W_DATA, W_INDEX and W_LAST until the handshake.
- Fixed latencies with W_READY=1:
  - First W_VALID in the cycle after START acceptance.
  - Words in consecutive cycles.
  - DONE DEPTH+1 cycles after START acceptance.
- DEPTH=1: the first word carries W_LAST=1.
- Address never wraps, guaranteed by the elaboration check.

Optional Feature:
- Macro WEIGHT_READER_CHECKSUM_EN.
- Defined:
  - Adds output CHECKSUM [DATA_W-1:0], a modulo-2**DATA_W sum of every W_DATA word handshaked in the current pass.
  - CHECKSUM clears to 0 on START acceptance and on reset.
  - CHECKSUM is stable from the DONE cycle until the next START.
- Undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package ann_weight_pkg holds:
  - Constants WEIGHT_W=16, WEIGHT_ADDR_W=5, WEIGHTS_PER_NEURON=28.
  - FSM state typedef weight_rd_state_t {IDLE, RUN, DRAIN}.
- One sub-module: weight_rd_fifo2, a 2-entry synchronous FIFO with count output and async active-low reset.

Test Plan:
- Basic pass: BRAM model holds word i = 16'h0100+i, W_READY=1, START at cycle 0.
  - W_VALID cycles 1..28 with W_DATA 16'h0100..16'h011B and W_INDEX 0..27.
  - W_LAST only at index 27; DONE high in cycle 29 only; BRAM_WE=0 throughout.
- Backpressure: same pass with W_READY=0 on cycles 5-9 and random 50% thereafter.
  - Identical 28-word sequence, no loss or duplicate.
  - W_DATA stable while stalled; at most 2 issued-but-unaccepted reads.
- START while BUSY at cycle 10: ignored, exactly one DONE. Then START in the DONE cycle: second pass begins with BUSY continuous and the same 28 words.
- Reset mid-pass: RST_N low at cycle 12.
  - All outputs 0 immediately.
  - After release and a new START, a full 28-word pass from index 0.
- Parameters BASE_ADDR=4, DEPTH=1: one word (model word 4) with W_LAST=1, DONE 2 cycles after START.
- With WEIGHT_READER_CHECKSUM_EN: the basic pass gives CHECKSUM = sum(0x0100..0x011B) = 16'h1D7A at DONE.
